// File: rtl/stream_delay_line_pkg.sv
// Shared definitions for the Avalon-ST stream delay line: mode encoding,
// controller states and the width of one stored line.
package stream_delay_line_pkg;

  localparam logic MODE_BEAT  = 1'b0;
  localparam logic MODE_CYCLE = 1'b1;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A stored line is {data, sop, eop, empty, tag}; the struct itself is
  // declared next to its users because its widths are module parameters.
  localparam int LINE_CTRL_W = 3;

  function automatic int line_width(input int data_w, input int empty_w);
    return data_w + empty_w + LINE_CTRL_W;
  endfunction

endpackage

// File: rtl/stream_delay_line_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module sdp_ram
  import stream_delay_line_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

`ifdef __ICARUS__
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] = '0;
    rdata_q = '0;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_delay_line.sv
// Runtime-programmable Avalon-ST delay line over a circular RAM, with
// priming, automatic idle-drain, forced flush and flush inhibit.
module stream_delay_line
  import stream_delay_line_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int ADDR_W  = 10,
  parameter int IDLE_W  = 16
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic [ADDR_W-1:0]  cfg_delay,
  input  logic               cfg_load,
  input  logic               cfg_mode,
  input  logic               flush_force,
  input  logic               flush_inhibit,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               primed,
  output logic               draining
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic               tag;
  } line_t;

  localparam int LINE_W = line_width(DATA_W, EMPTY_W);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [IDLE_W-1:0] ONE_I = IDLE_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0]   d_q, d_d;
  logic                mode_q, mode_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                vld_q;
  logic                seen_q;

  logic                primed_w;
  logic                idle_sat;
  logic                force_adv;
  logic                drain_adv;
  logic                adv;
  logic [ADDR_W-1:0]   rd_addr;
  line_t               wr_line;
  line_t               rd_line;

  assign primed_w  = (state_q != ST_PRIME);
  assign idle_sat  = &idle_cnt_q;
  assign force_adv = flush_force & ~flush_inhibit;
  assign drain_adv = (state_q == ST_DRAIN) & ~flush_inhibit;
  assign adv       = (mode_q == MODE_CYCLE) | in_valid | force_adv | drain_adv;
  // d_q is never 0, so the read slot never collides with the write slot.
  assign rd_addr   = wr_addr_q - d_q;

  always_comb begin
    wr_line = '0;
    if (in_valid) begin
      wr_line.data  = in_data;
      wr_line.sop   = in_sop;
      wr_line.eop   = in_eop;
      wr_line.empty = in_empty;
      wr_line.tag   = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    d_d         = d_q;
    mode_d      = mode_q;
    wr_addr_d   = adv ? (wr_addr_q + ONE_A) : wr_addr_q;

    unique case (state_q)
      ST_PRIME: begin
        idle_cnt_d = '0;
        if (adv) begin
          fill_cnt_d = fill_cnt_q + ONE_A;
          if (fill_cnt_d == d_q) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_valid)       idle_cnt_d = '0;
        else if (!idle_sat) idle_cnt_d = idle_cnt_q + ONE_I;
        if (idle_sat && !flush_inhibit && (mode_q == MODE_BEAT)) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + ONE_A;
        if ((drain_cnt_q == (d_q - ONE_A)) || in_valid || flush_inhibit) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end
      end
      default: state_d = ST_PRIME;
    endcase

    // A reload re-primes from scratch; any packet in flight is truncated.
    if (cfg_load) begin
      d_d        = (cfg_delay == '0) ? ONE_A : cfg_delay;
      mode_d     = cfg_mode;
      fill_cnt_d = '0;
      state_d    = ST_PRIME;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PRIME;
      wr_addr_q   <= '0;
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      idle_cnt_q  <= '0;
      d_q         <= ONE_A;
      mode_q      <= MODE_BEAT;
      vld_q       <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      d_q         <= d_d;
      mode_q      <= mode_d;
      vld_q       <= adv & primed_w;
      if (adv) seen_q <= 1'b1;
    end
  end

  sdp_ram #(
    .WIDTH  (LINE_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (sys_clk),
    .we_i    (adv),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_line),
    .re_i    (adv),
    .raddr_i (rd_addr),
    .rdata_o (rd_line)
  );

  // The RAM read register is the output register; seen_q hides its
  // unreset contents until the first read after reset.
  assign out_valid = vld_q & rd_line.tag;
  assign out_sop   = out_valid & rd_line.sop;
  assign out_eop   = out_valid & rd_line.eop;
  assign out_empty = out_eop ? rd_line.empty : '0;
  assign out_data  = seen_q ? rd_line.data : '0;
  assign primed    = primed_w;
  assign draining  = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_stream_delay_line.sv
// Randomised directed bench for stream_delay_line against a history-based model.
module tb_stream_delay_line;

  localparam int DW = 32;
  localparam int EW = 3;
  localparam int AW = 10;
  localparam int IW = 4;
  localparam int IDLE_MAX = (1 << IW) - 1;

  logic          sys_clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic          in_valid, in_sop, in_eop;
  logic [EW-1:0] in_empty;
  logic [AW-1:0] cfg_delay;
  logic          cfg_load, cfg_mode, flush_force, flush_inhibit;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop;
  logic [EW-1:0] out_empty;
  logic          primed, draining;

  stream_delay_line #(.DATA_W(DW), .EMPTY_W(EW), .ADDR_W(AW), .IDLE_W(IW)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .cfg_delay(cfg_delay), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .flush_force(flush_force), .flush_inhibit(flush_inhibit),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .primed(primed), .draining(draining)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          tag;
  } ent_t;

  // Model: every advance appends to a linear history; a primed advance n
  // presents history entry n-D on the following cycle.
  ent_t          hist [int];
  int            m_adv, m_d, m_state, m_fill, m_idle, m_drain;
  bit            m_mode;
  bit            e_valid, e_sop, e_eop, e_seen;
  logic [DW-1:0] e_data;
  logic [EW-1:0] e_empty;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_adv = 0; m_d = 1; m_state = 0; m_fill = 0; m_idle = 0; m_drain = 0; m_mode = 0;
    e_valid = 0; e_sop = 0; e_eop = 0; e_seen = 0; e_data = '0; e_empty = '0;
  endtask

  task automatic model_eval();
    bit   adv;
    int   idx;
    ent_t w;
    adv = m_mode || in_valid || (flush_force && !flush_inhibit) || (m_state == 2 && !flush_inhibit);
    e_valid = 0; e_sop = 0; e_eop = 0; e_empty = '0;
    if (adv) begin
      e_seen = 1;
      idx = m_adv - m_d;
      if (m_state != 0 && hist.exists(idx) && hist[idx].tag) begin
        e_valid = 1;
        e_data  = hist[idx].data;
        e_sop   = hist[idx].sop;
        e_eop   = hist[idx].eop;
        e_empty = hist[idx].eop ? hist[idx].empty : '0;
      end
      w.data = '0; w.sop = 0; w.eop = 0; w.empty = '0; w.tag = 0;
      if (in_valid) begin
        w.data = in_data; w.sop = in_sop; w.eop = in_eop; w.empty = in_empty; w.tag = 1;
      end
      hist[m_adv] = w;
      m_adv++;
    end
    if (cfg_load) begin
      m_d = (cfg_delay == 0) ? 1 : int'(cfg_delay);
      m_mode = cfg_mode; m_fill = 0; m_state = 0; m_idle = 0;
    end else if (m_state == 0) begin
      m_idle = 0;
      if (adv) begin
        m_fill++;
        if (m_fill == m_d) m_state = 1;
      end
    end else if (m_state == 1) begin
      if (m_idle == IDLE_MAX && !flush_inhibit && !m_mode) begin
        m_state = 2; m_drain = 0;
      end
      if (in_valid) m_idle = 0;
      else if (m_idle < IDLE_MAX) m_idle++;
    end else begin
      if (m_drain == m_d - 1 || in_valid || flush_inhibit) begin
        m_state = 1; m_idle = 0;
      end else m_drain++;
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, e_valid);
    chk("out_sop", out_sop, e_sop);
    chk("out_eop", out_eop, e_eop);
    chk("out_empty", out_empty, e_empty);
    chk("primed", primed, m_state != 0);
    chk("draining", draining, m_state == 2);
    if (e_valid)      chk("out_data", out_data, e_data);
    else if (!e_seen) chk("out_data_rst", out_data, 0);
  endtask

  task automatic step();
    model_eval();
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    in_valid = 0; in_sop = 0; in_eop = 0; in_empty = '0; cfg_load = 0; flush_force = 0;
  endtask

  task automatic set_beat(input logic [DW-1:0] d, input bit s, input bit e, input logic [EW-1:0] em);
    in_valid = 1; in_data = d; in_sop = s; in_eop = e; in_empty = em;
  endtask

  task automatic load(input int d, input bit mode);
    cfg_delay = AW'(d); cfg_mode = mode; cfg_load = 1;
    step();
    cfg_load = 0;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_sop"}, out_sop, 0);
    chk({tag, "_eop"}, out_eop, 0);
    chk({tag, "_empty"}, out_empty, 0);
    chk({tag, "_primed"}, primed, 0);
    chk({tag, "_draining"}, draining, 0);
  endtask

  initial begin
    int            first_i, nval, ndrain, nbeats, lat;
    logic [DW-1:0] first_d, prev_d, last_d, pkt [5];
    logic [EW-1:0] got_empty;
    bit            last_eop;

    reset_n = 0; in_data = '0; cfg_delay = '0; cfg_mode = 0; flush_inhibit = 0;
    idle_in();
    model_reset();
    #23;
    reset_chk("rst");
    reset_n = 1;

    // D=4 BEAT mode, beats 1..10
    load(4, 0);
    first_i = 0; first_d = '0; nval = 0;
    for (int i = 1; i <= 10; i++) begin
      set_beat(DW'(i), i == 1, i == 10, '0);
      step();
      if (i == 3) chk("s1_primed_b3", primed, 0);
      if (i == 4) chk("s1_primed_b4", primed, 1);
      if (out_valid) begin
        nval++;
        if (first_i == 0) begin first_i = i; first_d = out_data; end
      end
    end
    idle_in();
    chk("s1_first_beat", first_i, 5);
    chk("s1_first_data", first_d, 1);
    chk("s1_nvalid", nval, 6);

    // CYCLE mode D=8, single-beat packet
    load(8, 1);
    repeat (10) step();
    set_beat($urandom, 1, 1, 3'd5);
    first_d = in_data;
    step();
    idle_in();
    nval = out_valid; lat = 0; got_empty = '0; last_d = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (out_valid) begin nval++; lat = k + 1; got_empty = out_empty; last_d = out_data; end
    end
    chk("s2_nvalid", nval, 1);
    chk("s2_latency", lat, 9);
    chk("s2_empty", got_empty, 5);
    chk("s2_data", last_d, first_d);

    // BEAT mode D=3, 5-beat packet then idle -> auto-drain
    load(3, 0);
    for (int i = 0; i < 5; i++) begin
      pkt[i] = $urandom;
      set_beat(pkt[i], i == 0, i == 4, 3'($urandom_range(7)));
      step();
    end
    idle_in();
    nval = 0; ndrain = 0; last_eop = 0; last_d = '0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (draining) ndrain++;
      if (out_valid) begin nval++; last_eop = out_eop; last_d = out_data; end
    end
    chk("s3_drain_cycles", ndrain, 3);
    chk("s3_nvalid", nval, 3);
    chk("s3_last_eop", last_eop, 1);
    chk("s3_last_data", last_d, pkt[4]);
    chk("s3_back_to_run", primed && !draining, 1);

    // Same with flush_inhibit
    load(3, 0);
    flush_inhibit = 1;
    for (int i = 0; i < 5; i++) begin
      pkt[i] = $urandom;
      set_beat(pkt[i], i == 0, i == 4, '0);
      step();
    end
    idle_in();
    nval = 0; ndrain = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (draining) ndrain++;
      if (out_valid) nval++;
    end
    flush_force = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (out_valid) nval++;
    end
    chk("s4_inh_drain", ndrain, 0);
    chk("s4_inh_held", nval, 0);
    flush_inhibit = 0;
    nval = 0; last_eop = 0; last_d = '0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) flush_force = 0;
      step();
      if (out_valid) begin nval++; last_eop = out_eop; last_d = out_data; end
    end
    chk("s4_released", nval, 3);
    chk("s4_rel_eop", last_eop, 1);
    chk("s4_rel_data", last_d, pkt[4]);

    // cfg_delay=0 behaves as D=1
    load(0, 0);
    for (int i = 0; i < 6; i++) begin
      set_beat($urandom, 1, 1, 3'($urandom_range(7)));
      step();
      if (i > 0) begin
        chk("s5_valid", out_valid, 1);
        chk("s5_data", out_data, prev_d);
      end
      prev_d = in_data;
      idle_in();
      step();
      chk("s5_gap_valid", out_valid, 0);
    end

    // D=1023 past two wraps, then mid-stream reload to D=2
    load(1023, 0);
    nval = 0; nbeats = 0;
    for (int k = 0; k < 2400; k++) begin
      in_valid = ($urandom_range(7) != 0);
      in_data = $urandom; in_sop = 1'($urandom); in_eop = 1'($urandom); in_empty = 3'($urandom);
      if (in_valid) nbeats++;
      step();
      if (out_valid) nval++;
    end
    chk("s6_nvalid", nval, nbeats - 1023);
    set_beat($urandom, 0, 0, '0);
    load(2, 0);
    for (int k = 0; k < 2; k++) begin
      set_beat($urandom, 1'($urandom), 1'($urandom), 3'($urandom));
      step();
      chk("s6_reload_masked", out_valid, 0);
    end
    for (int k = 0; k < 20; k++) begin
      set_beat($urandom, 1'($urandom), 1'($urandom), 3'($urandom));
      step();
    end

    // asynchronous reset mid-stream
    #2 reset_n = 0;
    #1 reset_chk("midrst");
    model_reset();
    #20 reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      set_beat($urandom, 1, 1, '0);
      step();
      if (i == 0) chk("s6_reprime", out_valid, 0);
      else        chk("s6_reprime_data", out_data, prev_d);
      prev_d = in_data;
    end
    idle_in();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
